// File: rtl/conv_seq_pkg.sv
// Shared state encoding and sizing helpers for the convolution frame sequencer.
package conv_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      FLUSH,
      DONE
   } state_t;

   function automatic int total_pix(input int img_w, input int img_h);
      return img_w * img_h;
   endfunction

   // Two full line buffers must drain, plus slack for the engine's own pipeline.
   function automatic int flush_len(input int img_w, input int pad);
      return 2 * img_w + pad;
   endfunction

   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/conv_frame_sequencer_if.sv
// Bundle of the input-RAM read port, engine pixel port and output-RAM write port.
interface conv_frame_sequencer_if #(
   parameter int ADDR_W = 19
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic              conv_clear;
   logic              conv_en;
   logic [7:0]        conv_pixel;
   logic              conv_valid;
   logic [7:0]        conv_out;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (
      output rd_en, rd_addr, conv_clear, conv_en, conv_pixel, wr_en, wr_addr, wr_data,
      input  rd_data, conv_valid, conv_out
   );

   modport slave (
      input  rd_en, rd_addr, conv_clear, conv_en, conv_pixel, wr_en, wr_addr, wr_data,
      output rd_data, conv_valid, conv_out
   );
endinterface

// File: rtl/conv_out_tracker.sv
// Output capture: write counter/address, overflow flag and, with
// CONV_SEQ_BORDER_ZERO_EN defined, row/col tracking that zeroes border pixels.
module conv_out_tracker
   import conv_seq_pkg::*;
#(
   parameter int IMG_W  = 480,
   parameter int IMG_H  = 857,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              cap_en,
   input  logic [7:0]        conv_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [ADDR_W:0]   out_count,
   output logic              overflow
);

   localparam logic [ADDR_W:0] TOTAL_C = (ADDR_W + 1)'(total_pix(IMG_W, IMG_H));

   logic       room;
   logic       take;
   logic [7:0] wdata_next;

   assign room = (out_count < TOTAL_C);
   assign take = cap_en && room;

`ifdef CONV_SEQ_BORDER_ZERO_EN
   localparam int COL_W = cnt_w(IMG_W - 1);
   localparam int ROW_W = cnt_w(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             border;

   assign border     = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
   assign wdata_next = border ? 8'd0 : conv_out;

   // Position of the pixel about to be written; advances only on real writes.
   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         col <= '0;
         row <= '0;
      end else if (take) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end
`else
   assign wdata_next = conv_out;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= 8'd0;
         out_count <= '0;
         overflow  <= 1'b0;
      end else if (clr) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         out_count <= '0;
         overflow  <= 1'b0;
      end else begin
         wr_en <= take;
         if (take) begin
            wr_addr   <= out_count[ADDR_W-1:0];
            wr_data   <= wdata_next;
            out_count <= out_count + 1'b1;
         end
         if (cap_en && !room) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller: clears the 3x3 engine, streams one frame from the input RAM,
// flushes with zero pixels and captures engine outputs into the output RAM.
module conv_frame_sequencer
   import conv_seq_pkg::*;
#(
   parameter int IMG_W     = 480,
   parameter int IMG_H     = 857,
   parameter int FLUSH_PAD = 200,
   parameter int ADDR_W    = 19
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   short_frame,
   output logic                   overflow,
   output logic [ADDR_W:0]        out_count,
   conv_frame_sequencer_if.master bus
);

   localparam int FLUSH_LEN = flush_len(IMG_W, FLUSH_PAD);
   localparam int FL_W      = cnt_w(FLUSH_LEN);
   localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(FLUSH_LEN);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(total_pix(IMG_W, IMG_H) - 1);
   localparam logic [ADDR_W:0]   TOTAL_C    = (ADDR_W + 1)'(total_pix(IMG_W, IMG_H));

   state_t          state;
   logic [FL_W-1:0] flush_cnt;
   logic            ram_pix_p1;
   logic            accept;
   logic            cap_en;

   assign accept = (state == IDLE) && start;
   assign cap_en = bus.conv_valid && (state inside {STREAM, FLUSH, DONE});

   // RAM data lands one cycle after the read, in step with the delayed strobe.
   assign bus.conv_pixel = ram_pix_p1 ? bus.rd_data : 8'd0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         short_frame    <= 1'b0;
         bus.rd_en      <= 1'b0;
         bus.rd_addr    <= '0;
         bus.conv_clear <= 1'b0;
         bus.conv_en    <= 1'b0;
         ram_pix_p1     <= 1'b0;
         flush_cnt      <= '0;
      end else begin
         done           <= 1'b0;
         bus.conv_clear <= 1'b0;
         // Flush cycles issue a zero pixel on the same one-cycle delay as reads.
         bus.conv_en    <= bus.rd_en || ((state == FLUSH) && (flush_cnt != FLUSH_LAST));
         ram_pix_p1     <= bus.rd_en;
         case (state)
            IDLE: begin
               if (start) begin
                  state          <= CLEAR;
                  busy           <= 1'b1;
                  short_frame    <= 1'b0;
                  bus.conv_clear <= 1'b1;
               end
            end
            CLEAR: begin
               state       <= STREAM;
               bus.rd_en   <= 1'b1;
               bus.rd_addr <= '0;
            end
            STREAM: begin
               if (bus.rd_addr == LAST_ADDR) begin
                  state     <= FLUSH;
                  bus.rd_en <= 1'b0;
                  flush_cnt <= '0;
               end else begin
                  bus.rd_addr <= bus.rd_addr + 1'b1;
               end
            end
            // Stays one cycle past the last zero issue so done follows the final pixel.
            FLUSH: begin
               if (flush_cnt == FLUSH_LAST) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  short_frame <= (out_count < TOTAL_C);
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   conv_out_tracker #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_tracker (
      .clk       (clk),
      .reset     (reset),
      .clr       (accept),
      .cap_en    (cap_en),
      .conv_out  (bus.conv_out),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .out_count (out_count),
      .overflow  (overflow)
   );

endmodule
